// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
// The magnitude helper is used at operand capture time.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER  = 32;
    localparam int CNT_W     = $clog2(DIV_ITER);
    localparam logic [DIV_WIDTH-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // |INT_MIN| wraps back to 0x80000000, which is the correct unsigned magnitude
    function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] x);
        return x[DIV_WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// Shifts {rem, quo} left and keeps the trial subtraction when it does not borrow.
module div_step
    import div_pkg::*;
(
    input  logic [DIV_WIDTH:0]   rem,
    input  logic [DIV_WIDTH-1:0] quo,
    input  logic [DIV_WIDTH-1:0] div,
    output logic [DIV_WIDTH:0]   next_rem,
    output logic [DIV_WIDTH-1:0] next_quo
);

    logic [DIV_WIDTH+1:0] shifted;
    logic [DIV_WIDTH+1:0] trial;

    // One extra guard bit keeps the borrow test exact for any remainder value
    always_comb begin
        shifted  = {rem, quo[DIV_WIDTH-1]};
        trial    = shifted - {2'b00, div};
        next_quo = {quo[DIV_WIDTH-2:0], 1'b0};
        next_rem = shifted[DIV_WIDTH:0];
        if (!trial[DIV_WIDTH+1]) begin
            next_rem    = trial[DIV_WIDTH:0];
            next_quo[0] = 1'b1;
        end
    end

endmodule

// File: rtl/div_seq.sv
// Sequential 32-bit signed divider: capture, 32 restoring iterations, sign fix, result pulse.
// A new ctrl_DIV in any state abandons the current division and restarts.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    div_state_t state, next_state;

    logic [WIDTH:0]     rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   div_q;
    logic [CNT_W-1:0]   count_q;
    logic               sign_q;
    logic               ovf_q;
    logic [WIDTH-1:0]   res_q;
    logic               exc_q;

    logic [WIDTH:0]     step_rem;
    logic [WIDTH-1:0]   step_quo;
    logic               b_zero;
    logic               last_iter;

    assign b_zero    = (data_operandB == '0);
    assign last_iter = (count_q == CNT_W'(DIV_ITER - 1));

    div_step u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .div      (div_q),
        .next_rem (step_rem),
        .next_quo (step_quo)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A start pulse wins over whatever the FSM was doing; zero divisors skip the loop
    always_comb begin
        next_state = state;
        if (ctrl_DIV) begin
            next_state = b_zero ? DONE : RUN;
        end else begin
            case (state)
                IDLE:    next_state = IDLE;
                RUN:     next_state = last_iter ? FIX : RUN;
                FIX:     next_state = DONE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Result and exception are staged in res_q/exc_q and only published in DONE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rem_q          <= '0;
            quo_q          <= '0;
            div_q          <= '0;
            count_q        <= '0;
            sign_q         <= 1'b0;
            ovf_q          <= 1'b0;
            res_q          <= '0;
            exc_q          <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_DIV) begin
                sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                ovf_q   <= (data_operandA == INT_MIN) && (data_operandB == '1);
                quo_q   <= abs_val(data_operandA);
                div_q   <= abs_val(data_operandB);
                rem_q   <= '0;
                count_q <= '0;
                if (b_zero) begin
                    res_q <= '0;
                    exc_q <= 1'b1;
                end
            end else begin
                case (state)
                    RUN: begin
                        rem_q   <= step_rem;
                        quo_q   <= step_quo;
                        count_q <= count_q + 1'b1;
                    end
                    FIX: begin
                        exc_q <= ovf_q;
                        if (ovf_q) begin
                            res_q <= INT_MIN;
                        end else begin
                            res_q <= sign_q ? (~quo_q + 1'b1) : quo_q;
                        end
                    end
                    DONE: begin
                        data_result    <= res_q;
                        data_exception <= exc_q;
                        data_resultRDY <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vector table, corner sequences, random vs. arithmetic model.
// Expected quotients come from native signed integer division.
module tb_div_seq;

    logic        clock;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        e;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    div_seq #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: truncating signed division, with the two exceptional cases
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic e, output int lat);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'd0; e = 1'b1; lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; e = 1'b1; lat = 34;
        end else begin
            q = sa / sb; e = 1'b0; lat = 34;
        end
    endtask

    // Drives a one-cycle ctrl_DIV pulse, then scrambles the operands
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic waitResult(output logic [31:0] res, output logic exc, output int lat);
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (data_resultRDY) break;
        end
        res = data_result;
        exc = data_exception;
    endtask

    task automatic runVector(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] eq, input logic ee, input int elat);
        logic [31:0] res;
        logic        exc;
        int          lat;
        applyStimulus(a, b);
        waitResult(res, exc, lat);
        checkOutput({tag, "_result"}, res, eq);
        checkOutput({tag, "_exc"}, 32'(exc), 32'(ee));
        checkOutput({tag, "_latency"}, 32'(lat), 32'(elat));
        @(negedge clock);
        checkOutput({tag, "_rdy_width"}, 32'(data_resultRDY), 32'd0);
        checkOutput({tag, "_hold"}, data_result, eq);
    endtask

    initial begin
        logic [31:0] res, eq, ra, rb;
        logic        exc, ee;
        int          lat, elat, pulses;

        vecs[0] = '{32'd100,        32'd7,          32'd14,         1'b0, 34};
        vecs[1] = '{32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b0, 34};
        vecs[2] = '{32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  1'b0, 34};
        vecs[3] = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0, 34};
        vecs[4] = '{32'd12345,      32'd0,          32'd0,          1'b1, 1};
        vecs[5] = '{32'd6,          32'd3,          32'd2,          1'b0, 34};
        vecs[6] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, 34};
        vecs[7] = '{32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0, 34};
        vecs[8] = '{32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'd1,          1'b0, 34};

        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (2) @(negedge clock);
        checkOutput("reset_result", data_result, 32'd0);
        checkOutput("reset_exc", 32'(data_exception), 32'd0);
        checkOutput("reset_rdy", 32'(data_resultRDY), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].e, vecs[i].lat);
        end

        // Abort: second pulse at iteration 10 must yield a single result
        applyStimulus(32'd1000, 32'd3);
        pulses = 0;
        repeat (9) begin
            @(negedge clock);
            if (data_resultRDY) pulses++;
        end
        runVector("abort", 32'd50, 32'd5, 32'd10, 1'b0, 34);
        checkOutput("abort_no_early_rdy", 32'(pulses), 32'd0);

        // ctrl_DIV held high for three cycles: only the final operands complete
        @(negedge clock);
        ctrl_DIV = 1'b1; data_operandA = 32'd500; data_operandB = 32'd5;
        @(posedge clock); #1;
        data_operandA = 32'd600; data_operandB = 32'd4;
        @(posedge clock); #1;
        data_operandA = 32'd77;  data_operandB = 32'd7;
        @(posedge clock); #1;
        ctrl_DIV = 1'b0; data_operandA = $urandom; data_operandB = $urandom;
        waitResult(res, exc, lat);
        checkOutput("held_result", res, 32'd11);
        checkOutput("held_latency", 32'(lat), 32'd34);

        // Reset at iteration 20: outputs clear at once, and no pulse follows
        applyStimulus(32'd1000, 32'd3);
        repeat (20) @(posedge clock);
        #2;
        checkOutput("pre_reset_result", data_result, 32'd11);
        reset = 1'b1;
        #1;
        checkOutput("midreset_result", data_result, 32'd0);
        checkOutput("midreset_exc", 32'(data_exception), 32'd0);
        checkOutput("midreset_rdy", 32'(data_resultRDY), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) pulses++;
        end
        checkOutput("midreset_no_rdy", 32'(pulses), 32'd0);
        runVector("after_reset", 32'd9, 32'd2, 32'd4, 1'b0, 34);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = $urandom;
                1:       rb = $urandom_range(1, 100);
                2:       rb = -($urandom_range(1, 100));
                3:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'hFFFF_FFFF;
            endcase
            if (i == 0) ra = 32'h8000_0000;
            model(ra, rb, eq, ee, elat);
            runVector($sformatf("rand%0d", i), ra, rb, eq, ee, elat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Sequential 32-bit signed integer divider for the CPU multdiv unit. Captures operands on a `ctrl_DIV` pulse and produces one quotient bit per cycle by restoring division on magnitudes, then applies the sign. Flags divide-by-zero and the single overflow case through `data_exception`. The divisor zero-detect result gates entry to the iteration loop; the ALU/writeback stage consumes the quotient.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width; the only supported value is 32.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `ctrl_DIV`  in  1  start pulse; sampled each rising edge.
- `data_operandA`  in  32  dividend, two's complement; sampled only when `ctrl_DIV`=1.
- `data_operandB`  in  32  divisor, two's complement; sampled only when `ctrl_DIV`=1.
- `data_result`  out  32  quotient, two's complement, truncated toward zero.
- `data_exception`  out  1  1 for divide-by-zero or 0x80000000 / 0xFFFFFFFF.
- `data_resultRDY`  out  1  one-cycle pulse marking valid `data_result` / `data_exception`.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: on `ctrl_DIV`=1, latch sign_q = A[31]^B[31], |A| into the quotient register, |B| into the divisor register (32-bit unsigned; |0x80000000| = 0x80000000), clear the 33-bit remainder register, and set count=0.
  - If B==0: go to DONE with result 0 and exception 1.
  - Otherwise go to RUN.
- RUN, one iteration per cycle:
  - Shift {rem, quo} left by 1.
  - Compute trial = rem − {0, div} (33 bits).
  - If trial[32]==0: rem=trial and quo[0]=1. Otherwise restore rem and set quo[0]=0.
  - count increments each cycle. After count reaches 31, go to FIX.
- FIX: result = sign_q ? −quo : quo (32-bit wrap).
  - exception=1 iff A was 0x80000000 and B was 0xFFFFFFFF. In that case result = 0x80000000.
  - Go to DONE.
- DONE: assert `data_resultRDY` for exactly this cycle, then return to IDLE.
- `data_result` and `data_exception` hold their last values until the next DONE.
- The remainder is discarded.
- `ctrl_DIV`=1 in any state aborts the current operation and restarts from the new operands, exactly as from IDLE. No `data_resultRDY` is issued for the aborted operation.
- `ctrl_DIV` held high across multiple cycles restarts every cycle; only the last pulse completes.

## Timing
- Reset values: state IDLE, count 0, `data_result`=0, `data_exception`=0, `data_resultRDY`=0, all internal registers 0.
- Reset asserted mid-operation returns to IDLE immediately, with no `data_resultRDY` pulse.
- Normal latency, with `ctrl_DIV` sampled at edge E0:
  - RUN spans edges E1–E32.
  - FIX occurs at E33.
  - `data_resultRDY`=1 in the cycle between E34 and E35.
  - `data_result` and `data_exception` are valid from E34 onward.
- Divide-by-zero latency: DONE is entered at E1. `data_resultRDY`=1 in the cycle between E1 and E2, with result 0 and exception 1.
- No input is sampled outside the `ctrl_DIV` cycle. Operand changes during RUN have no effect.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `div_pkg`:
  - state enum (IDLE, RUN, FIX, DONE), 2-bit encoding;
  - `DIV_WIDTH`=32;
  - `DIV_ITER`=32;
  - `INT_MIN`=32'h80000000.
- One sub-module, `div_step`: combinational single restoring iteration.
  - Inputs: rem[32:0], quo[31:0], div[31:0].
  - Outputs: next rem, next quo.
- The top level holds the FSM, counter, registers, and sign/exception logic, plus a zero-detect on the divisor at the capture cycle.

## Test plan
- A=100, B=7 -> `data_resultRDY` pulses exactly 34 cycles after the `ctrl_DIV` edge; result 14; exception 0.
- A=−100 (0xFFFFFF9C), B=7 -> result 0xFFFFFFF2 (−14); A=100, B=−7 -> 0xFFFFFFF2; A=−100, B=−7 -> 14; all with exception 0.
- A=12345, B=0 -> `data_resultRDY` one cycle after the `ctrl_DIV` edge; result 0; exception 1. A following 6/3 then returns 2 with exception 0.
- A=0x80000000, B=0xFFFFFFFF -> result 0x80000000, exception 1. A=0x80000000, B=1 -> 0x80000000, exception 0. A=0x7FFFFFFF, B=0x7FFFFFFF -> 1.
- Start 1000/3, then pulse `ctrl_DIV` with 50/5 at iteration 10 -> a single `data_resultRDY` 34 cycles after the second pulse, with result 10.
- Assert `reset` at iteration 20 -> outputs read 0 immediately, with no `data_resultRDY` pulse. A new 9/2 then returns 4.
